bus_arbiter: RTL



---
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared 16-bit memory bus.
// Requests are serialised into fixed-length memory transactions. Each
// transaction runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE, and every
// output is registered.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   req          per-master request level, sampled only in IDLE
//   we           per-master write (1) / read (0)
//   addr_in      master i address in bits [16i+15:16i]
//   wdata_in     master i write data, same packing
//   grant        one-hot bus owner, 0 when idle
//   done         one-cycle completion pulse to the owner
//   rdata        read data, valid while done is high
//   mem_address  shared bus address
//   mem_r/mem_w  read/write strobes
//   mem_wdata    write data to memory
//   mem_rdata    read data from memory
module bus_arbiter #(
  parameter int MASTERS      = 3,
  parameter int WAIT_CYCLES  = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MASTERS-1:0]     req,
  input  logic [MASTERS-1:0]     we,
  input  logic [16*MASTERS-1:0]  addr_in,
  input  logic [16*MASTERS-1:0]  wdata_in,
  output logic [MASTERS-1:0]     grant,
  output logic [MASTERS-1:0]     done,
  output logic [15:0]            rdata,
  output logic [15:0]            mem_address,
  output logic                   mem_r,
  output logic                   mem_w,
  output logic [15:0]            mem_wdata,
  input  logic [15:0]            mem_rdata
);

  localparam int          IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned NM = MASTERS;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state, w_state_n;
  logic [IW-1:0]       r_idx, r_last;
  logic                r_we;
  logic [3:0]          r_cnt;

  logic [IW-1:0]       w_win, w_cand;
  logic                w_found;

  logic [IW-1:0]       w_idx_n, w_last_n;
  logic                w_we_n;
  logic [3:0]          w_cnt_n;
  logic [MASTERS-1:0]  w_grant_n, w_done_n;
  logic [15:0]         w_rdata_n, w_addr_n, w_wdata_n;
  logic                w_r_n, w_w_n;

  // Winner selection: scan last+1, last+2, ... (mod MASTERS); optional CPU override.
  always_comb begin
    w_win   = r_last;
    w_cand  = '0;
    w_found = 1'b0;
    if (CPU_PRIORITY != 0 && req[0]) begin
      w_win   = '0;
      w_found = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NM; k++) begin
        w_cand = IW'((32'(r_last) + k) % NM);
        if (!w_found && req[w_cand]) begin
          w_win   = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (|req)         w_state_n = S_ACCESS;
      S_ACCESS: if (r_cnt == '0)  w_state_n = S_DONE;
      S_DONE:                     w_state_n = S_IDLE;
      default:                    w_state_n = S_IDLE;
    endcase
  end

  // Output/datapath next values; computed against the transition so that
  // the registered outputs line up with the state being entered.
  always_comb begin
    w_idx_n   = r_idx;
    w_last_n  = r_last;
    w_we_n    = r_we;
    w_cnt_n   = r_cnt;
    w_grant_n = grant;
    w_done_n  = '0;
    w_rdata_n = rdata;
    w_addr_n  = mem_address;
    w_r_n     = mem_r;
    w_w_n     = mem_w;
    w_wdata_n = mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_idx_n   = w_win;
          w_last_n  = w_win;
          w_we_n    = we[w_win];
          w_cnt_n   = 4'(WAIT_CYCLES - 1);
          w_grant_n = MASTERS'(1) << w_win;
          w_addr_n  = addr_in[16*w_win +: 16];
          w_r_n     = !we[w_win];
          w_w_n     = we[w_win];
          w_wdata_n = we[w_win] ? wdata_in[16*w_win +: 16] : '0;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          if (!r_we) w_rdata_n = mem_rdata;
          w_addr_n  = '0;
          w_r_n     = 1'b0;
          w_w_n     = 1'b0;
          w_wdata_n = '0;
          w_done_n  = MASTERS'(1) << r_idx;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_grant_n = '0;
        w_rdata_n = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_last      <= IW'(MASTERS - 1);
      r_we        <= 1'b0;
      r_cnt       <= '0;
      grant       <= '0;
      done        <= '0;
      rdata       <= '0;
      mem_address <= '0;
      mem_r       <= 1'b0;
      mem_w       <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      r_idx       <= w_idx_n;
      r_last      <= w_last_n;
      r_we        <= w_we_n;
      r_cnt       <= w_cnt_n;
      grant       <= w_grant_n;
      done        <= w_done_n;
      rdata       <= w_rdata_n;
      mem_address <= w_addr_n;
      mem_r       <= w_r_n;
      mem_w       <= w_w_n;
      mem_wdata   <= w_wdata_n;
    end
  end

endmodule
